// File: rtl/out_stream_packer.sv
// Output-side stream buffer: FWFT FIFO between the Stride stage and the DDR write path.
// Counts the beats of each frame against a programmed length, drives a frame-accurate
// M_Last, pulses Frame_Complete and flags S_Last/count disagreement.
module out_stream_packer #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH_BEAT      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [WIDTH_BEAT-1:0] Beat_Num_REG,
    input  logic [DATA_WIDTH-1:0] S_Data,
    input  logic                  S_Valid,
    output logic                  S_Ready,
    input  logic                  S_Last,
    output logic [DATA_WIDTH-1:0] M_Data,
    output logic                  M_Valid,
    input  logic                  M_Ready,
    output logic                  M_Last,
    output logic                  Frame_Complete,
    output logic                  Last_Mismatch,
    output logic                  Busy
);

    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] OccFull = (FIFO_DEPTH_LOG2 + 1)'(Depth);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [WIDTH_BEAT-1:0]      n_q, n_d;
    logic [WIDTH_BEAT-1:0]      in_cnt_q, in_cnt_d;
    logic [WIDTH_BEAT-1:0]      out_cnt_q, out_cnt_d;
    logic                       mismatch_q, mismatch_d;

    logic [DATA_WIDTH-1:0]      mem_q [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   occ_q, occ_d;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       wr_en;
    logic                       rd_en;
    logic                       m_last;
    logic [WIDTH_BEAT-1:0]      n_last;

    // FIFO status, handshakes and stream outputs
    always_comb begin
        fifo_full  = (occ_q == OccFull);
        fifo_empty = (occ_q == '0);
        // N==0 wraps n_last to all-ones; in_cnt<N keeps that frame from accepting anything
        n_last     = n_q - WIDTH_BEAT'(1);
        // No bypass at full: a same-cycle read does not open S_Ready
        S_Ready    = (state_q == StRun) && !fifo_full && (in_cnt_q < n_q);
        M_Valid    = !fifo_empty;
        // Gate data with valid so the port reads zero while nothing is buffered
        M_Data     = M_Valid ? mem_q[rd_ptr_q] : '0;
        m_last     = M_Valid && (state_q != StIdle) && (out_cnt_q == n_last);
        M_Last     = m_last;
        wr_en      = S_Valid && S_Ready;
        rd_en      = M_Valid && M_Ready;
        Frame_Complete = (state_q == StDone);
        Last_Mismatch  = mismatch_q;
        Busy           = (state_q != StIdle);
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + (FIFO_DEPTH_LOG2 + 1)'(1);
            2'b01:   occ_d = occ_q - (FIFO_DEPTH_LOG2 + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Frame FSM, beat counters and mismatch flag next-state
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        mismatch_d = mismatch_q;

        if (wr_en) begin
            in_cnt_d = in_cnt_q + WIDTH_BEAT'(1);
            if (S_Last != (in_cnt_q == n_last)) begin
                mismatch_d = 1'b1;
            end
        end
        if (rd_en) begin
            out_cnt_d = out_cnt_q + WIDTH_BEAT'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    n_d        = Beat_Num_REG;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    mismatch_d = 1'b0;
                    state_d    = (Beat_Num_REG == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // The count is authoritative: the frame ends on the final beat leaving
                if (rd_en && m_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            mismatch_q <= mismatch_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy governs visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= S_Data;
        end
    end

endmodule
